// File: rtl/input_conditioner.sv
// Synchronizes, debounces and edge-detects the stopwatch play button and slide switches.
// Delivers clean levels plus press / long-hold / switch-change pulses, all registered.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 100000000,
    parameter int unsigned N_SW            = 3,
    parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            play_btn_raw,
    input  logic [N_SW-1:0] sw_raw,
    output logic            play_level,
    output logic            play_press,
    output logic            play_hold,
    output logic [N_SW-1:0] sw_clean,
    output logic            sw_changed
);

    localparam int unsigned NCH = N_SW + 1;
    localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW  = $clog2(HOLD_CYCLES + 1);
    localparam logic        BTN_INV = (BTN_ACTIVE_LOW != 0);
    // Channel 0 is the button; its raw idle level is the inverted one when active-low
    localparam logic [NCH-1:0] INV_MASK = {{N_SW{1'b0}}, BTN_INV};
    localparam logic [CW-1:0]  DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } btn_state_t;

    logic [NCH-1:0] raw_c;
    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync2_q;
    logic [NCH-1:0] ch_in_c;
    logic [NCH-1:0] stable_q;
    logic [CW-1:0]  cnt_q [NCH];
    logic [NCH-1:0] differ_c;
    logic [NCH-1:0] accept_c;
    logic           rise_c;
    logic           fall_c;

    btn_state_t     state_q;
    btn_state_t     state_d;
    logic [HW-1:0]  hcnt_q;
    logic [HW-1:0]  hcnt_d;
    logic           press_d;
    logic           hold_d;

    assign raw_c = {sw_raw, play_btn_raw};

    // Two-flop synchronizers, reset to the inactive raw level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= INV_MASK;
            sync2_q <= INV_MASK;
        end else begin
            sync1_q <= raw_c;
            sync2_q <= sync1_q;
        end
    end

    assign ch_in_c = sync2_q ^ INV_MASK;

    always_comb begin
        differ_c = '0;
        accept_c = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            differ_c[i] = (ch_in_c[i] != stable_q[i]);
            accept_c[i] = differ_c[i] && (cnt_q[i] == DEB_LAST);
        end
    end

    // Per-channel debouncer: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NCH); i++) begin
                if (accept_c[i]) begin
                    stable_q[i] <= ch_in_c[i];
                    cnt_q[i]    <= '0;
                end else if (differ_c[i]) begin
                    cnt_q[i]    <= cnt_q[i] + CW'(1);
                end else begin
                    cnt_q[i]    <= '0;
                end
            end
        end
    end

    assign rise_c = accept_c[0] && ch_in_c[0];
    assign fall_c = accept_c[0] && !ch_in_c[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            hcnt_q     <= '0;
            play_press <= 1'b0;
            play_hold  <= 1'b0;
            sw_changed <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            play_press <= press_d;
            play_hold  <= hold_d;
            sw_changed <= |accept_c[NCH-1:1];
        end
    end

    // Button FSM; a release accepted on the hold edge wins over the hold pulse
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        press_d = 1'b0;
        hold_d  = 1'b0;
        case (state_q)
            IDLE: begin
                hcnt_d = '0;
                if (rise_c) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                if (fall_c) begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                end else if (hcnt_q == HOLD_LAST) begin
                    state_d = HELD;
                    hold_d  = 1'b1;
                end else begin
                    hcnt_d  = hcnt_q + HW'(1);
                end
            end
            HELD: begin
                if (fall_c) begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                hcnt_d  = '0;
            end
        endcase
    end

    assign play_level = stable_q[0];
    assign sw_clean   = stable_q[NCH-1:1];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a cycle-stamped expectation scoreboard.
module tb_input_conditioner;

    logic       clk;
    logic       reset;
    logic       play_btn_raw;
    logic [2:0] sw_raw;
    logic       play_level;
    logic       play_press;
    logic       play_hold;
    logic [2:0] sw_clean;
    logic       sw_changed;

    typedef struct {
        int         cyc;
        string      tag;
        logic [6:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   n_press;
    int   n_hold;
    int   n_chg;

    input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10),
        .N_SW           (3),
        .BTN_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .play_btn_raw(play_btn_raw),
        .sw_raw      (sw_raw),
        .play_level  (play_level),
        .play_press  (play_press),
        .play_hold   (play_hold),
        .sw_clean    (sw_clean),
        .sw_changed  (sw_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] mk(input logic lvl, input logic prs, input logic hld,
                                      input logic [2:0] sw, input logic chg);
        return {lvl, prs, hld, sw, chg};
    endfunction

    function automatic logic [6:0] observed();
        return {play_level, play_press, play_hold, sw_clean, sw_changed};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (lvl,prs,hld,sw[2:0],chg) at cycle %0d",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_in(input int d, input string tag, input logic [6:0] val);
        exp_t e;
        e.cyc = cyc + d;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    // Advance one edge, sample #1 later, tally pulses and service due expectations
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        n_press += int'(play_press);
        n_hold  += int'(play_hold);
        n_chg   += int'(sw_changed);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check(sb[i].tag, observed(), sb[i].val);
                sb.delete(i);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_counts();
        n_press = 0;
        n_hold  = 0;
        n_chg   = 0;
    endtask

    initial begin
        cyc = 0; n_tests = 0; n_fail = 0;
        clr_counts();
        reset = 1'b1;
        play_btn_raw = 1'b1;
        sw_raw = 3'b000;
        ticks(2);
        check("reset_state", observed(), mk(0, 0, 0, 3'b000, 0));
        reset = 1'b0;
        ticks(2);
        check("idle_after_reset", observed(), mk(0, 0, 0, 3'b000, 0));

        // Clean press and long hold
        clr_counts();
        play_btn_raw = 1'b0;
        expect_in(5,  "press_before_latency", mk(0, 0, 0, 3'b000, 0));
        expect_in(6,  "press_at_latency",     mk(1, 1, 0, 3'b000, 0));
        expect_in(7,  "press_single_cycle",   mk(1, 0, 0, 3'b000, 0));
        expect_in(15, "hold_before_10",       mk(1, 0, 0, 3'b000, 0));
        expect_in(16, "hold_at_10",           mk(1, 0, 1, 3'b000, 0));
        expect_in(17, "hold_single_cycle",    mk(1, 0, 0, 3'b000, 0));
        ticks(20);
        check_int("clean_press_count", n_press, 1);
        check_int("clean_hold_count", n_hold, 1);
        play_btn_raw = 1'b1;
        expect_in(5, "release_before_latency", mk(1, 0, 0, 3'b000, 0));
        expect_in(6, "release_at_latency",     mk(0, 0, 0, 3'b000, 0));
        ticks(8);
        check_int("held_no_extra_hold", n_hold, 1);
        check_int("held_no_extra_press", n_press, 1);

        // Bounce: 2-cycle toggles never pass the filter
        clr_counts();
        for (int i = 0; i < 10; i++) begin
            play_btn_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            ticks(2);
        end
        check_int("bounce_no_press", n_press, 0);
        check("bounce_level_low", observed(), mk(0, 0, 0, 3'b000, 0));
        play_btn_raw = 1'b0;
        expect_in(5, "bounce_settle_pre",  mk(0, 0, 0, 3'b000, 0));
        expect_in(6, "bounce_settle_press", mk(1, 1, 0, 3'b000, 0));
        ticks(6);
        play_btn_raw = 1'b1;
        ticks(10);
        check_int("bounce_one_press", n_press, 1);
        check_int("bounce_no_hold", n_hold, 0);

        // Short press: debounced release 8 cycles after press
        clr_counts();
        play_btn_raw = 1'b0;
        ticks(8);
        play_btn_raw = 1'b1;
        expect_in(5, "short_release_pre", mk(1, 0, 0, 3'b000, 0));
        expect_in(6, "short_release_at",  mk(0, 0, 0, 3'b000, 0));
        ticks(12);
        check_int("short_no_hold", n_hold, 0);
        check_int("short_one_press", n_press, 1);

        // Release accepted on the same edge the hold count expires
        clr_counts();
        play_btn_raw = 1'b0;
        ticks(10);
        play_btn_raw = 1'b1;
        expect_in(5, "race_pre",          mk(1, 0, 0, 3'b000, 0));
        expect_in(6, "race_release_wins", mk(0, 0, 0, 3'b000, 0));
        ticks(12);
        check_int("race_no_hold", n_hold, 0);

        // Switches: simultaneous change gives one strobe, short glitch ignored
        clr_counts();
        sw_raw = 3'b101;
        expect_in(5, "sw_pre",         mk(0, 0, 0, 3'b000, 0));
        expect_in(6, "sw_change",      mk(0, 0, 0, 3'b101, 1));
        expect_in(7, "sw_change_once", mk(0, 0, 0, 3'b101, 0));
        ticks(10);
        check_int("sw_one_pulse", n_chg, 1);
        clr_counts();
        sw_raw = 3'b111;
        ticks(3);
        sw_raw = 3'b101;
        ticks(10);
        check_int("sw_glitch_no_pulse", n_chg, 0);
        check("sw_glitch_level", observed(), mk(0, 0, 0, 3'b101, 0));

        // Reset in PRESSED aborts the hold; held inputs re-detected after release
        clr_counts();
        play_btn_raw = 1'b0;
        expect_in(6, "pre_reset_press", mk(1, 1, 0, 3'b101, 0));
        ticks(11);
        reset = 1'b1;
        expect_in(1, "reset_clears_all", mk(0, 0, 0, 3'b000, 0));
        ticks(2);
        reset = 1'b0;
        clr_counts();
        expect_in(5, "post_reset_pre",   mk(0, 0, 0, 3'b000, 0));
        expect_in(6, "post_reset_press", mk(1, 1, 0, 3'b101, 1));
        expect_in(7, "post_reset_once",  mk(1, 0, 0, 3'b101, 0));
        ticks(8);
        play_btn_raw = 1'b1;
        ticks(10);
        check_int("post_reset_no_hold", n_hold, 0);
        check_int("post_reset_one_press", n_press, 1);
        check_int("post_reset_one_change", n_chg, 1);

        check_int("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Synchronizes, debounces and edge-detects the stopwatch's raw board inputs (play push-button and the mode/pause slide switches) before they reach the processor's PIO ports. It sits directly upstream of the stopwatch top level. It delivers clean switch levels, a single-cycle press pulse and a long-hold pulse for the play button, so software never sees contact bounce or metastable samples.

## Interface
- DEBOUNCE_CYCLES, 500000 — consecutive stable cycles required to accept a new input level (10 ms at 50 MHz); must be ≥1
- HOLD_CYCLES, 100000000 — cycles the debounced button must stay pressed after its press pulse to fire a hold pulse (2 s at 50 MHz); must be ≥1
- N_SW, 3 — number of slide switches (mode0, mode1, pause)
- BTN_ACTIVE_LOW, 1 — 1: raw button reads 0 when pressed

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- play_btn_raw  in  1  raw push-button pin, asynchronous
- sw_raw  in  N_SW  raw slide-switch pins, asynchronous, active-high
- play_level  out  1  debounced button level, 1 = pressed
- play_press  out  1  one-cycle pulse on debounced press
- play_hold  out  1  one-cycle pulse when press held HOLD_CYCLES
- sw_clean  out  N_SW  debounced switch levels
- sw_changed  out  1  one-cycle pulse when any sw_clean bit changes

## Operation
- Each input passes through a 2-flop synchronizer. The button is inverted after synchronization when BTN_ACTIVE_LOW=1.
- Each of the N_SW+1 channels has its own debouncer: a stable register and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Synchronized value ≠ stable: counter increments.
  - Synchronized value = stable: counter clears to 0.
  - Counter reaches DEBOUNCE_CYCLES-1 while still differing: stable takes the new value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is discarded.
- Button FSM, states IDLE, PRESSED, HELD:
  - IDLE → PRESSED on debounced rise; play_press=1 for that one cycle.
  - PRESSED: hold counter increments each cycle. When it reaches HOLD_CYCLES-1: play_hold=1 for one cycle, go to HELD.
  - PRESSED or HELD → IDLE on debounced fall; the hold counter clears.
  - No further pulses fire in HELD. A new press is required.
- sw_changed is the OR of per-channel change strobes. Simultaneous changes on several switches give a single pulse.
- The hold counter saturates; it never wraps.

## Timing
- Reset values:
  - play_level=0, play_press=0, play_hold=0, sw_clean=0, sw_changed=0.
  - Synchronizer flops hold the inactive level; counters are 0; FSM is in IDLE.
- Reset takes priority over every other event in the same cycle.
- Reset asserted mid-count or in PRESSED/HELD aborts the operation: no pulse is emitted and every register returns to its reset value on the next edge.
- Latency: a raw level held steady appears on play_level / sw_clean exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it (2 synchronizer + DEBOUNCE_CYCLES filter).
- play_press and sw_changed are asserted in the same cycle the corresponding clean level first shows its new value.
- play_hold is asserted exactly HOLD_CYCLES cycles after the play_press cycle.
- If HOLD_CYCLES elapses on the same edge the debounced fall is accepted, the release wins: no hold pulse, FSM goes to IDLE.
- An input asserted during reset and still asserted after reset release is treated as a new change. It produces play_press / sw_changed DEBOUNCE_CYCLES+2 cycles after release.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, N_SW=3, BTN_ACTIVE_LOW=1.

- Clean press: drive play_btn_raw 1→0 and hold it → play_level=1 and a single play_press pulse 6 cycles later. play_hold pulses exactly 10 cycles after play_press.
- Bounce: toggle play_btn_raw every 2 cycles for 20 cycles, then hold it at 0 → no pulse during the toggling. Exactly one play_press occurs 6 cycles after the final stable level.
- Short press: hold the button pressed for 8 cycles after play_press, then release → play_level falls 6 cycles after the release. No play_hold pulse.
- Switches: change sw_raw from 3'b000 to 3'b101 in one cycle → sw_clean=3'b101 after 6 cycles with one sw_changed pulse. A 3-cycle glitch on bit1 produces no change.
- Reset mid-operation: assert reset while in PRESSED, 5 cycles into the hold count → all outputs are 0 the next cycle and no play_hold ever fires. With the button still held after reset release, play_press fires 6 cycles after release.
